// File: rtl/vga_sync_rx.sv
// vga_sync_rx: locks onto an external hs/vs pair, measures line and
// frame totals, and regenerates de/x/y in the pixel clock domain.
module vga_sync_rx #(
  parameter int CNT_W       = 11,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int H_START     = 184,
  parameter int H_ACTIVE    = 800,
  parameter int V_START     = 29,
  parameter int V_ACTIVE    = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk_px,
  input  logic             rst,
  input  logic             hs,
  input  logic             vs,
  output logic             locked,
  output logic             lost,
  output logic             sat_err,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int MW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0] H_LO  = (CNT_W+1)'(H_START);
  localparam logic [CNT_W:0] H_ACT = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] V_LO  = (CNT_W+1)'(V_START);
  localparam logic [CNT_W:0] V_ACT = (CNT_W+1)'(V_ACTIVE);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_FRAMES);

  logic [1:0]       hs_q;
  logic [1:0]       vs_q;
  logic             hs_act;
  logic             vs_act;
  logic             hs_edge;
  logic             vs_edge;
  logic [CNT_W-1:0] h_cnt_q;
  logic [CNT_W-1:0] h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q;
  logic [CNT_W-1:0] v_cnt_d;
  logic [CNT_W-1:0] h_tot_q;
  logic [CNT_W-1:0] h_tot_d;
  logic [CNT_W-1:0] v_tot_q;
  logic [CNT_W-1:0] v_tot_d;
  logic [CNT_W-1:0] h_inc;
  logic [CNT_W-1:0] v_inc;
  logic             h_sat;
  logic             v_sat;
  logic             h_bad;
  logic             sat_q;
  logic             sat_d;
  logic             unst_q;
  logic             unst_d;
  logic             frame_ok;
  state_e           state_q;
  logic [MW-1:0]    match_q;
  logic [MW-1:0]    match_inc;
  logic             locked_q;
  logic             lost_q;
  logic [CNT_W:0]   h_off;
  logic [CNT_W:0]   v_off;
  logic             h_in;
  logic             v_in;
  logic             de_q;
  logic             de_d;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] x_d;
  logic [CNT_W-1:0] y_q;
  logic [CNT_W-1:0] y_d;

  assign hs_act  = (HS_POL != 0) ? hs : ~hs;
  assign vs_act  = (VS_POL != 0) ? vs : ~vs;
  assign hs_edge = hs_q[0] & ~hs_q[1];
  assign vs_edge = vs_q[0] & ~vs_q[1];

  always_comb begin
    h_inc   = h_cnt_q + 1'b1;
    v_inc   = v_cnt_q + 1'b1;
    h_sat   = (h_cnt_q == CNT_MAX);
    v_sat   = (v_cnt_q == CNT_MAX);
    h_bad   = hs_edge && (h_inc != h_tot_q);
    h_cnt_d = h_cnt_q;
    h_tot_d = h_tot_q;
    v_cnt_d = v_cnt_q;
    v_tot_d = v_tot_q;
    sat_d   = sat_q;
    if (hs_edge) begin
      h_cnt_d = '0;
      h_tot_d = h_inc;
      if (v_sat) sat_d = 1'b1;
      else       v_cnt_d = v_inc;
    end else if (h_sat) begin
      sat_d = 1'b1;
    end else begin
      h_cnt_d = h_inc;
    end
    // vs edge owns the line counter even when hs lands in the same cycle
    if (vs_edge) begin
      v_cnt_d = '0;
      v_tot_d = v_inc;
      sat_d   = sat_q | (!hs_edge && h_sat);
    end
    unst_d   = vs_edge ? 1'b0 : (unst_q | h_bad);
    frame_ok = !(unst_q | h_bad) && (v_inc == v_tot_q) && !sat_q;
  end

  always_comb begin
    match_inc = match_q + 1'b1;
    h_off     = {1'b0, h_cnt_q} - H_LO;
    v_off     = {1'b0, v_cnt_q} - V_LO;
    h_in      = !h_off[CNT_W] && (h_off < H_ACT);
    v_in      = !v_off[CNT_W] && (v_off < V_ACT);
    de_d      = locked_q && h_in && v_in;
    x_d       = de_d ? h_off[CNT_W-1:0] : '0;
    y_d       = de_d ? v_off[CNT_W-1:0] : '0;
  end

  always_ff @(posedge clk_px) begin
    if (rst) begin
      hs_q    <= '0;
      vs_q    <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_tot_q <= '0;
      v_tot_q <= '0;
      sat_q   <= 1'b0;
      unst_q  <= 1'b0;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      hs_q    <= {hs_q[0], hs_act};
      vs_q    <= {vs_q[0], vs_act};
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      h_tot_q <= h_tot_d;
      v_tot_q <= v_tot_d;
      sat_q   <= sat_d;
      unst_q  <= unst_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_ff @(posedge clk_px) begin
    if (rst) begin
      state_q  <= SEARCH;
      match_q  <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      unique case (state_q)
        SEARCH: begin
          if (vs_edge) begin
            state_q <= TRACK;
            match_q <= '0;
          end
        end
        TRACK: begin
          if (vs_edge) begin
            if (!frame_ok) begin
              match_q <= '0;
            end else if (match_inc == LOCK_N) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              match_q  <= match_inc;
            end else begin
              match_q <= match_inc;
            end
          end
        end
        LOCKED: begin
          if (vs_edge && !frame_ok) begin
            state_q  <= TRACK;
            match_q  <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= SEARCH;
          match_q  <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked  = locked_q;
  assign lost    = lost_q;
  assign sat_err = sat_q;
  assign h_total = h_tot_q;
  assign v_total = v_tot_q;
  assign de      = de_q;
  assign x       = x_q;
  assign y       = y_q;

endmodule
